id_ex_stage: RTL and testbench

- Decode stage plus ID/EX pipeline register for the pipelined MIPS core.
- Takes the fetched instruction and drives the register-file read addresses (Ard1/Ard2).
- Captures the register-file read data (Dout1/Dout2), with write-back bypass applied, into registered operands for the ALU stage.
- Decodes control fields, sign/zero-extends immediates, detects load-use hazards (stall) and supports flush.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/mips_decoder.sv | 97 +++++++++
 rtl/id_ex_stage.sv | 177 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU codes
// and the decoded control bundle passed from ID to EX.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_SLT = 4'd4
   } alu_op_e;

   typedef struct packed {
      alu_op_e    alu_op;
      logic       alu_src;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_wr;
      logic       reads_rt;
      logic [4:0] dst;
   } ctrl_t;

endpackage

// File: rtl/mips_decoder.sv
// Combinational MIPS instruction decode: control bundle
// plus the sign- or zero-extended immediate.
module mips_decoder
   import mips_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [31:0]   Instr_i,
   output ctrl_t         Ctrl_o,
   output logic [DW-1:0] Imm_o
);

   logic [5:0]  op;
   logic [5:0]  fn;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm16;
   logic        sext;
   logic        unused_bits;
   ctrl_t       c;

   assign op    = Instr_i[31:26];
   assign fn    = Instr_i[5:0];
   assign rt    = Instr_i[20:16];
   assign rd    = Instr_i[15:11];
   assign imm16 = Instr_i[15:0];

   assign unused_bits = ^{Instr_i[25:21], Instr_i[10:6]};

   // Opcode/funct to control bits; unknown encodings become NOPs
   always_comb begin
      c        = '0;
      c.alu_op = ALU_ADD;
      sext     = 1'b0;
      unique case (op)
         OP_RTYPE: begin
            c.reads_rt = 1'b1;
            c.dst      = rd;
            c.reg_wr   = 1'b1;
            unique case (fn)
               FN_ADD:  c.alu_op = ALU_ADD;
               FN_SUB:  c.alu_op = ALU_SUB;
               FN_AND:  c.alu_op = ALU_AND;
               FN_OR:   c.alu_op = ALU_OR;
               FN_SLT:  c.alu_op = ALU_SLT;
               default: begin
                  c.reg_wr = 1'b0;
                  c.dst    = '0;
               end
            endcase
         end
         OP_ADDI: begin
            c.alu_src = 1'b1;
            c.reg_wr  = 1'b1;
            c.dst     = rt;
            sext      = 1'b1;
         end
         OP_ANDI: begin
            c.alu_op  = ALU_AND;
            c.alu_src = 1'b1;
            c.reg_wr  = 1'b1;
            c.dst     = rt;
         end
         OP_ORI: begin
            c.alu_op  = ALU_OR;
            c.alu_src = 1'b1;
            c.reg_wr  = 1'b1;
            c.dst     = rt;
         end
         OP_LW: begin
            c.alu_src = 1'b1;
            c.mem_rd  = 1'b1;
            c.reg_wr  = 1'b1;
            c.dst     = rt;
            sext      = 1'b1;
         end
         OP_SW: begin
            c.alu_src  = 1'b1;
            c.mem_wr   = 1'b1;
            c.reads_rt = 1'b1;
            sext       = 1'b1;
         end
         default: begin
            c.alu_op = ALU_ADD;
         end
      endcase
      // Writes to $0 are discarded
      if (c.dst == 5'd0) begin
         c.reg_wr = 1'b0;
      end
   end

   assign Ctrl_o = c;
   assign Imm_o  = sext ? {{(DW-16){imm16[15]}}, imm16}
                        : {{(DW-16){1'b0}}, imm16};

endmodule

// File: rtl/id_ex_stage.sv
// MIPS decode stage with WB bypass, load-use stall
// detection and the ID/EX pipeline register.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          IfId_Valid,
   input  logic [31:0]   IfId_Instr,
   input  logic          Flush,
   output logic [AW-1:0] Rf_Ard1,
   output logic [AW-1:0] Rf_Ard2,
   input  logic [DW-1:0] Rf_Dout1,
   input  logic [DW-1:0] Rf_Dout2,
   input  logic          Wb_WrEn,
   input  logic [AW-1:0] Wb_Awr,
   input  logic [DW-1:0] Wb_Din,
   output logic          Stall,
   output logic          IdEx_Valid,
   output logic [DW-1:0] IdEx_A,
   output logic [DW-1:0] IdEx_B,
   output logic [DW-1:0] IdEx_Imm,
   output logic [AW-1:0] IdEx_Rs,
   output logic [AW-1:0] IdEx_Rt,
   output logic [AW-1:0] IdEx_Dst,
   output logic [3:0]    IdEx_AluOp,
   output logic          IdEx_AluSrc,
   output logic          IdEx_MemRd,
   output logic          IdEx_MemWr,
   output logic          IdEx_RegWr
);

   ctrl_t         ctrl;
   logic [DW-1:0] imm;
   logic [AW-1:0] rs;
   logic [AW-1:0] rt;
   logic [AW-1:0] dec_dst;
   logic [DW-1:0] opa;
   logic [DW-1:0] opb;
   logic          hazard;
   logic          bubble;

   logic          valid_q, valid_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [DW-1:0] imm_q, imm_d;
   logic [AW-1:0] rs_q, rs_d;
   logic [AW-1:0] rt_q, rt_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [3:0]    aluop_q, aluop_d;
   logic          alusrc_q, alusrc_d;
   logic          memrd_q, memrd_d;
   logic          memwr_q, memwr_d;
   logic          regwr_q, regwr_d;

   assign rs      = IfId_Instr[25:21];
   assign rt      = IfId_Instr[20:16];
   assign Rf_Ard1 = rs;
   assign Rf_Ard2 = rt;

   mips_decoder #(
      .DW(DW)
   ) u_dec (
      .Instr_i(IfId_Instr),
      .Ctrl_o (ctrl),
      .Imm_o  (imm)
   );

   assign dec_dst = ctrl.dst;

   // Forward the WB value: the RF write lands on this same edge
   always_comb begin
      opa = Rf_Dout1;
      opb = Rf_Dout2;
      if (Wb_WrEn && (Wb_Awr != '0) && (Wb_Awr == rs)) begin
         opa = Wb_Din;
      end
      if (Wb_WrEn && (Wb_Awr != '0) && (Wb_Awr == rt)) begin
         opb = Wb_Din;
      end
      if (rs == '0) begin
         opa = '0;
      end
      if (rt == '0) begin
         opb = '0;
      end
   end

   // Load in EX whose result is needed by the instruction in ID
   always_comb begin
      hazard = 1'b0;
      if (IfId_Valid && valid_q && memrd_q && (dst_q != '0)) begin
         hazard = (dst_q == rs) || (ctrl.reads_rt && (dst_q == rt));
      end
   end

   assign Stall  = hazard && !Rst;
   assign bubble = Flush || Stall || !IfId_Valid;

   // Next ID/EX contents: latch decode or insert a bubble
   always_comb begin
      valid_d  = 1'b0;
      a_d      = a_q;
      b_d      = b_q;
      imm_d    = imm_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      dst_d    = dst_q;
      aluop_d  = aluop_q;
      alusrc_d = 1'b0;
      memrd_d  = 1'b0;
      memwr_d  = 1'b0;
      regwr_d  = 1'b0;
      if (!bubble) begin
         valid_d  = 1'b1;
         a_d      = opa;
         b_d      = opb;
         imm_d    = imm;
         rs_d     = rs;
         rt_d     = rt;
         dst_d    = dec_dst;
         aluop_d  = ctrl.alu_op;
         alusrc_d = ctrl.alu_src;
         memrd_d  = ctrl.mem_rd;
         memwr_d  = ctrl.mem_wr;
         regwr_d  = ctrl.reg_wr;
      end
   end

   // ID/EX pipeline register with synchronous reset
   always_ff @(posedge Clk) begin
      if (Rst) begin
         valid_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         dst_q    <= '0;
         aluop_q  <= '0;
         alusrc_q <= 1'b0;
         memrd_q  <= 1'b0;
         memwr_q  <= 1'b0;
         regwr_q  <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         a_q      <= a_d;
         b_q      <= b_d;
         imm_q    <= imm_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         dst_q    <= dst_d;
         aluop_q  <= aluop_d;
         alusrc_q <= alusrc_d;
         memrd_q  <= memrd_d;
         memwr_q  <= memwr_d;
         regwr_q  <= regwr_d;
      end
   end

   assign IdEx_Valid  = valid_q;
   assign IdEx_A      = a_q;
   assign IdEx_B      = b_q;
   assign IdEx_Imm    = imm_q;
   assign IdEx_Rs     = rs_q;
   assign IdEx_Rt     = rt_q;
   assign IdEx_Dst    = dst_q;
   assign IdEx_AluOp  = aluop_q;
   assign IdEx_AluSrc = alusrc_q;
   assign IdEx_MemRd  = memrd_q;
   assign IdEx_MemWr  = memwr_q;
   assign IdEx_RegWr  = regwr_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps
// followed by random traffic against a reference model.
module tb_id_ex_stage;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        IfId_Valid;
   logic [31:0] IfId_Instr;
   logic        Flush;
   logic [4:0]  Rf_Ard1, Rf_Ard2;
   logic [31:0] Rf_Dout1, Rf_Dout2;
   logic        Wb_WrEn;
   logic [4:0]  Wb_Awr;
   logic [31:0] Wb_Din;
   logic        Stall;
   logic        IdEx_Valid;
   logic [31:0] IdEx_A, IdEx_B, IdEx_Imm;
   logic [4:0]  IdEx_Rs, IdEx_Rt, IdEx_Dst;
   logic [3:0]  IdEx_AluOp;
   logic        IdEx_AluSrc, IdEx_MemRd, IdEx_MemWr, IdEx_RegWr;

   int checks = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   id_ex_stage dut (
      .Clk(Clk), .Rst(Rst),
      .IfId_Valid(IfId_Valid), .IfId_Instr(IfId_Instr),
      .Flush(Flush),
      .Rf_Ard1(Rf_Ard1), .Rf_Ard2(Rf_Ard2),
      .Rf_Dout1(Rf_Dout1), .Rf_Dout2(Rf_Dout2),
      .Wb_WrEn(Wb_WrEn), .Wb_Awr(Wb_Awr), .Wb_Din(Wb_Din),
      .Stall(Stall),
      .IdEx_Valid(IdEx_Valid),
      .IdEx_A(IdEx_A), .IdEx_B(IdEx_B), .IdEx_Imm(IdEx_Imm),
      .IdEx_Rs(IdEx_Rs), .IdEx_Rt(IdEx_Rt), .IdEx_Dst(IdEx_Dst),
      .IdEx_AluOp(IdEx_AluOp), .IdEx_AluSrc(IdEx_AluSrc),
      .IdEx_MemRd(IdEx_MemRd), .IdEx_MemWr(IdEx_MemWr),
      .IdEx_RegWr(IdEx_RegWr)
   );

   typedef struct {
      logic        known;
      logic        chk_src;
      logic [3:0]  op;
      logic        src, mrd, mwr, rwr, rrt;
      logic [4:0]  dst;
      logic [31:0] imm;
   } dec_t;

   // Expected pipeline-register contents
   logic        m_v, m_known, m_chksrc;
   logic [31:0] m_a, m_b, m_imm;
   logic [4:0]  m_rs, m_rt, m_dst;
   logic [3:0]  m_op;
   logic        m_src, m_mrd, m_mwr, m_rwr;
   logic        m_reset;

   function automatic dec_t ref_dec(logic [31:0] ins);
      dec_t d;
      logic [5:0] opc = ins[31:26];
      logic [5:0] fn  = ins[5:0];
      logic [31:0] se = {{16{ins[15]}}, ins[15:0]};
      logic [31:0] ze = {16'h0, ins[15:0]};
      d = '{default: '0};
      d.known = 1'b1;
      d.chk_src = 1'b1;
      if (opc == 6'h00) begin
         d.rrt = 1'b1; d.dst = ins[15:11]; d.rwr = 1'b1;
         if (fn == 6'h20) d.op = 4'd0;
         else if (fn == 6'h22) d.op = 4'd1;
         else if (fn == 6'h24) d.op = 4'd2;
         else if (fn == 6'h25) d.op = 4'd3;
         else if (fn == 6'h2A) d.op = 4'd4;
         else begin d.known = 1'b0; d.rwr = 1'b0; end
      end else if (opc == 6'h08) begin
         d.op = 4'd0; d.src = 1; d.imm = se; d.dst = ins[20:16]; d.rwr = 1;
      end else if (opc == 6'h0C) begin
         d.op = 4'd2; d.src = 1; d.imm = ze; d.dst = ins[20:16]; d.rwr = 1;
      end else if (opc == 6'h0D) begin
         d.op = 4'd3; d.src = 1; d.imm = ze; d.dst = ins[20:16]; d.rwr = 1;
      end else if (opc == 6'h23) begin
         d.op = 4'd0; d.imm = se; d.mrd = 1; d.rwr = 1; d.dst = ins[20:16];
         d.chk_src = 0;
      end else if (opc == 6'h2B) begin
         d.op = 4'd0; d.imm = se; d.mwr = 1; d.rrt = 1; d.chk_src = 0;
      end else begin
         d.known = 1'b0;
      end
      if (d.dst == 5'd0) d.rwr = 1'b0;
      return d;
   endfunction

   function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
   endfunction

   function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, logic [15:0] im);
      return {op, 5'(rs), 5'(rt), im};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_stall();
      logic [4:0] rs = IfId_Instr[25:21];
      logic [4:0] rt = IfId_Instr[20:16];
      dec_t d = ref_dec(IfId_Instr);
      if (Rst || !IfId_Valid || !m_v || !m_mrd || m_dst == 0) return 1'b0;
      return (m_dst == rs) || (d.rrt && m_dst == rt);
   endfunction

   function automatic logic [31:0] operand(logic [4:0] r, logic [31:0] rf);
      if (r == 0) return 32'h0;
      if (Wb_WrEn && Wb_Awr != 0 && Wb_Awr == r) return Wb_Din;
      return rf;
   endfunction

   task automatic model_edge(logic stl);
      dec_t d = ref_dec(IfId_Instr);
      m_reset = Rst;
      if (Rst) begin
         m_v = 0; m_a = 0; m_b = 0; m_imm = 0; m_rs = 0; m_rt = 0;
         m_dst = 0; m_op = 0; m_src = 0; m_mrd = 0; m_mwr = 0; m_rwr = 0;
         m_known = 0; m_chksrc = 0;
      end else if (Flush || stl || !IfId_Valid) begin
         m_v = 0; m_src = 0; m_mrd = 0; m_mwr = 0; m_rwr = 0;
      end else begin
         m_v = 1;
         m_a = operand(IfId_Instr[25:21], Rf_Dout1);
         m_b = operand(IfId_Instr[20:16], Rf_Dout2);
         m_rs = IfId_Instr[25:21];
         m_rt = IfId_Instr[20:16];
         m_known = d.known; m_chksrc = d.chk_src;
         m_op = d.op; m_src = d.src; m_imm = d.imm; m_dst = d.dst;
         m_mrd = d.mrd; m_mwr = d.mwr; m_rwr = d.rwr;
      end
   endtask

   task automatic check_outputs();
      chk("valid", 32'(IdEx_Valid), 32'(m_v));
      chk("memrd", 32'(IdEx_MemRd), 32'(m_mrd));
      chk("memwr", 32'(IdEx_MemWr), 32'(m_mwr));
      chk("regwr", 32'(IdEx_RegWr), 32'(m_rwr));
      if (m_reset) begin
         chk("rst_a", IdEx_A, 0);
         chk("rst_b", IdEx_B, 0);
         chk("rst_imm", IdEx_Imm, 0);
         chk("rst_regs", 32'({IdEx_Rs, IdEx_Rt, IdEx_Dst}), 0);
         chk("rst_alu", 32'({IdEx_AluOp, IdEx_AluSrc}), 0);
      end else if (m_v) begin
         chk("a", IdEx_A, m_a);
         chk("b", IdEx_B, m_b);
         chk("rs", 32'(IdEx_Rs), 32'(m_rs));
         chk("rt", 32'(IdEx_Rt), 32'(m_rt));
         if (m_known) begin
            chk("aluop", 32'(IdEx_AluOp), 32'(m_op));
            if (m_rwr || m_mrd) chk("dst", 32'(IdEx_Dst), 32'(m_dst));
            if (m_src) chk("imm", IdEx_Imm, m_imm);
            if (m_chksrc) chk("alusrc", 32'(IdEx_AluSrc), 32'(m_src));
         end
      end else begin
         chk("bub_alusrc", 32'(IdEx_AluSrc), 0);
      end
   endtask

   // One clock: apply inputs, check Stall, clock, check ID/EX
   task automatic cycle(logic rst, logic v, logic [31:0] ins, logic fl,
                        logic [31:0] d1, logic [31:0] d2,
                        logic we, logic [4:0] awr, logic [31:0] din);
      logic stl;
      Rst = rst; IfId_Valid = v; IfId_Instr = ins; Flush = fl;
      Rf_Dout1 = d1; Rf_Dout2 = d2;
      Wb_WrEn = we; Wb_Awr = awr; Wb_Din = din;
      #2;
      stl = exp_stall();
      chk("stall", 32'(Stall), 32'(stl));
      chk("ard1", 32'(Rf_Ard1), 32'(ins[25:21]));
      chk("ard2", 32'(Rf_Ard2), 32'(ins[20:16]));
      @(posedge Clk);
      model_edge(stl);
      #1;
      check_outputs();
   endtask

   initial begin
      logic [31:0] add3, lw2, add322, sw1;
      logic [5:0]  ops [9];
      logic [5:0]  fns [6];
      int          stalls;
      ops = '{6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h23, 6'h2B, 6'h3F};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h03};
      m_v = 0; m_mrd = 0; m_dst = 0; m_reset = 0;
      add3   = 32'h00221820;
      lw2    = i_ins(6'h23, 1, 2, 16'h0000);
      add322 = r_ins(2, 2, 3, 6'h20);
      sw1    = i_ins(6'h2B, 1, 5, 16'h0010);
      @(posedge Clk); #1;

      // Reset held two cycles with a valid instruction present
      cycle(1, 1, add3, 0, 5, 7, 0, 0, 0);
      cycle(1, 1, add3, 0, 5, 7, 0, 0, 0);

      // add $3,$1,$2
      cycle(0, 1, add3, 0, 5, 7, 0, 0, 0);
      chk("add_a", IdEx_A, 5);
      chk("add_b", IdEx_B, 7);
      chk("add_dst", 32'(IdEx_Dst), 3);
      chk("add_regwr", 32'(IdEx_RegWr), 1);

      // addi $4,$1,-1 and ori $4,$1,0xFFFF
      cycle(0, 1, 32'h2024FFFF, 0, 5, 7, 0, 0, 0);
      chk("addi_imm", IdEx_Imm, 32'hFFFFFFFF);
      chk("addi_src", 32'(IdEx_AluSrc), 1);
      chk("addi_dst", 32'(IdEx_Dst), 4);
      cycle(0, 1, i_ins(6'h0D, 1, 4, 16'hFFFF), 0, 5, 7, 0, 0, 0);
      chk("ori_imm", IdEx_Imm, 32'h0000FFFF);

      // WB bypass on rs, then disabled by Awr=0
      cycle(0, 1, add3, 0, 32'h1111, 7, 1, 1, 32'hDEAD);
      chk("byp_a", IdEx_A, 32'hDEAD);
      cycle(0, 1, add3, 0, 32'h1111, 7, 1, 0, 32'hDEAD);
      chk("byp_off_a", IdEx_A, 32'h1111);
      // Reads of $0 ignore RF data and bypass
      cycle(0, 1, r_ins(0, 0, 9, 6'h20), 0, 32'h55, 32'h66, 1, 0, 32'hBEEF);
      chk("zero_a", IdEx_A, 0);

      // Load-use: lw $2 then add $3,$2,$2 -> exactly one bubble
      cycle(0, 1, lw2, 0, 1, 2, 0, 0, 0);
      cycle(0, 1, add322, 0, 1, 2, 0, 0, 0);
      chk("lu_bubble", 32'(IdEx_Valid), 0);
      cycle(0, 1, add322, 0, 9, 9, 0, 0, 0);
      chk("lu_latch", 32'(IdEx_Valid), 1);
      chk("lu_dst", 32'(IdEx_Dst), 3);

      // Flush of a valid sw
      cycle(0, 1, sw1, 1, 1, 2, 0, 0, 0);
      chk("flush_v", 32'(IdEx_Valid), 0);
      chk("flush_mw", 32'(IdEx_MemWr), 0);

      // Flush together with a load-use stall
      cycle(0, 1, lw2, 0, 1, 2, 0, 0, 0);
      Rst = 0; IfId_Valid = 1; IfId_Instr = add322; Flush = 1; #2;
      chk("fl_st_stall", 32'(Stall), 1);
      cycle(0, 1, add322, 1, 1, 2, 0, 0, 0);
      chk("fl_st_v", 32'(IdEx_Valid), 0);

      // Random traffic against the model
      stalls = 0;
      for (int i = 0; i < 600; i++) begin
         logic [5:0]  op = ops[$urandom_range(0, 8)];
         logic [31:0] ins;
         if (op == 6'h00)
            ins = r_ins($urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), fns[$urandom_range(0, 5)]);
         else
            ins = i_ins(op, $urandom_range(0, 7), $urandom_range(0, 7),
                        16'($urandom));
         if (exp_stall()) stalls++;
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 85),
               ins, ($urandom_range(0, 9) == 0), $urandom, $urandom,
               $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
